keypad_entry: RTL

- Sits directly downstream of the row/column keypad scanner. Consumes its 4-bit key code and debounces it.
- Turns digit presses into a decimal number for the ATM processor (amounts, PINs). Issues the acknowledge pulse the scanner uses to blank repeats.
- Presents the finished number to the processor through a valid/ready handshake.

---
 rtl/keypad_pkg.sv | 20 ++
 rtl/keypad_debounce.sv | 54 +++++
 rtl/keypad_entry.sv | 120 ++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry block: scanner key codes, the
// "no key" rule and the entry state machine encoding.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;
    localparam logic [3:0] KEY_NONE = 4'd13;

    typedef enum logic [1:0] {
        ENTRY  = 2'd0,
        HELD   = 2'd1,
        SUBMIT = 2'd2
    } state_t;

    // Scanner codes 12..15 all mean that no key is down.
    function automatic logic is_none(input logic [3:0] code);
        return code >= 4'd12;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Two-flop synchronizer and stability counter for the scanner key code;
// emits one-cycle press/release strobes when the stable code changes.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int STABLE_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key_code,
    output logic [3:0] stable_code,
    output logic       press,
    output logic       released
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] FULL = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic [3:0]    syncA;
    logic [3:0]    syncB;
    logic [3:0]    candCode;
    logic [CW-1:0] count;

    // A change restarts the count at one because the new sample itself counts.
    always_ff @(posedge clock) begin
        if (reset) begin
            syncA       <= KEY_NONE;
            syncB       <= KEY_NONE;
            candCode    <= KEY_NONE;
            count       <= '0;
            stable_code <= KEY_NONE;
            press       <= 1'b0;
            released    <= 1'b0;
        end else begin
            syncA    <= key_code;
            syncB    <= syncA;
            press    <= 1'b0;
            released <= 1'b0;
            if (syncB != candCode) begin
                candCode <= syncB;
                count    <= CW'(1);
            end else if (count != FULL) begin
                count <= count + 1'b1;
                if (count == LAST) begin
                    stable_code <= candCode;
                    press       <= is_none(stable_code) && !is_none(candCode);
                    released    <= !is_none(stable_code) && is_none(candCode);
                end
            end
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Keypad digit entry: debounced key presses build a decimal value that is
// offered to the processor over valid/ready. KEYPAD_ENTRY_BCD_EN adds digits_bcd.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int MAX_DIGITS    = 6,
    parameter int VALUE_W       = 20,
    parameter int STABLE_CYCLES = 1000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         key_code,
    output logic               ack_key,
    output logic [VALUE_W-1:0] value,
    output logic [3:0]         digit_count,
    output logic               value_valid,
    input  logic               value_ready,
    output logic               overflow
`ifdef KEYPAD_ENTRY_BCD_EN
    ,
    output logic [4*MAX_DIGITS-1:0] digits_bcd
`endif
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

    logic [3:0] stableCode;
    logic       press;
    logic       released;
    state_t     state;
    state_t     nextState;
    logic       ackNext;
    logic       ovfNext;
    logic       validNext;
    logic       digitShift;
    logic       clearEntry;

    keypad_debounce #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_debounce (
        .clock      (clock),
        .reset      (reset),
        .key_code   (key_code),
        .stable_code(stableCode),
        .press      (press),
        .released   (released)
    );

    always_comb begin
        nextState  = state;
        ackNext    = 1'b0;
        ovfNext    = 1'b0;
        validNext  = value_valid;
        digitShift = 1'b0;
        clearEntry = 1'b0;
        case (state)
            ENTRY: begin
                if (press) begin
                    ackNext   = 1'b1;
                    nextState = HELD;
                    if (stableCode < 4'd10) begin
                        if (digit_count < MAX_CNT) digitShift = 1'b1;
                        else                       ovfNext    = 1'b1;
                    end else if (stableCode == KEY_STAR) begin
                        clearEntry = 1'b1;
                    end else if (stableCode == KEY_HASH && digit_count != 4'd0) begin
                        nextState = SUBMIT;
                    end
                end
            end
            HELD: begin
                if (released) nextState = ENTRY;
            end
            SUBMIT: begin
                // A key that became stable while waiting must still be released.
                if (value_valid && value_ready) begin
                    clearEntry = 1'b1;
                    validNext  = 1'b0;
                    nextState  = is_none(stableCode) ? ENTRY : HELD;
                end else begin
                    validNext = 1'b1;
                end
            end
            default: nextState = ENTRY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ENTRY;
            ack_key     <= 1'b0;
            overflow    <= 1'b0;
            value_valid <= 1'b0;
            value       <= '0;
            digit_count <= 4'd0;
        end else begin
            state       <= nextState;
            ack_key     <= ackNext;
            overflow    <= ovfNext;
            value_valid <= validNext;
            if (clearEntry) begin
                value       <= '0;
                digit_count <= 4'd0;
            end else if (digitShift) begin
                value       <= (value << 3) + (value << 1) + VALUE_W'(stableCode);
                digit_count <= digit_count + 4'd1;
            end
        end
    end

`ifdef KEYPAD_ENTRY_BCD_EN
    always_ff @(posedge clock) begin
        if (reset || clearEntry) digits_bcd <= '0;
        else if (digitShift)     digits_bcd <= (digits_bcd << 4) | (4*MAX_DIGITS)'(stableCode);
    end
`else
    // Without the display option only the binary value is kept.
`endif

endmodule
